// File: rtl/user_axis_pkt_csum.sv
// user_axis_pkt_csum: AXI4-Stream pass-through with a per-tid running 32-bit
// checksum. Every packet is followed by one trailer beat that carries its
// checksum in tdata[31:0]. The output is a single register slice.
// Optional build macro CSUM_STAT_EN adds per-ID packet/byte counters with a
// registered read port.

// Byte-masks one 32-bit lane: bytes whose keep bit is low read as zero.
module user_axis_pkt_csum_lane (
    input  logic [31:0] data,
    input  logic [3:0]  keep,
    output logic [31:0] masked
);
    // zero every byte the source marked as null
    always_comb begin
        masked = '0;
        for (int b = 0; b < 4; b++)
            if (keep[b]) masked[8*b +: 8] = data[8*b +: 8];
    end
endmodule

module user_axis_pkt_csum #(
    parameter  int          DATA_BITS = 512,
    parameter  int          N_ID      = 4,
    parameter  logic [31:0] CSUM_INIT = 32'h0000_0000,
    localparam int          ID_BITS   = (N_ID > 1) ? $clog2(N_ID) : 1,
    localparam int          KEEP_BITS = DATA_BITS / 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
`ifdef CSUM_STAT_EN
    input  logic [ID_BITS-1:0]   stat_sel,
    output logic [31:0]          stat_pkts,
    output logic [47:0]          stat_bytes,
    input  logic                 stat_clr,
`endif
    input  logic [DATA_BITS-1:0] s_tdata,
    input  logic [KEEP_BITS-1:0] s_tkeep,
    input  logic                 s_tlast,
    input  logic [ID_BITS-1:0]   s_tid,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [DATA_BITS-1:0] m_tdata,
    output logic [KEEP_BITS-1:0] m_tkeep,
    output logic                 m_tlast,
    output logic [ID_BITS-1:0]   m_tid,
    output logic                 m_tvalid,
    input  logic                 m_tready
);
    localparam int                 NUM_LANES = DATA_BITS / 32;
    localparam logic [ID_BITS:0]   N_ID_W    = (ID_BITS+1)'(N_ID);

    typedef enum logic {PASS = 1'b0, TRAIL = 1'b1} state_t;

    state_t                        state;
    logic [N_ID-1:0][31:0]         acc;
    logic [ID_BITS-1:0]            trl_id;
    logic [31:0]                   trl_csum;

    logic [NUM_LANES-1:0][31:0]    lane_m;
    logic [31:0]                   beat_sum;
    logic [31:0]                   acc_cur;
    logic [31:0]                   acc_next;
    logic                          id_ok;
    logic                          out_ld;
    logic                          accept;
    logic                          trl_load;

    // per-lane byte masking
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        user_axis_pkt_csum_lane u_lane (
            .data   (s_tdata[32*g +: 32]),
            .keep   (s_tkeep[4*g +: 4]),
            .masked (lane_m[g])
        );
    end

    // mod-2^32 sum of all masked lanes of the current input beat
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < NUM_LANES; i++)
            beat_sum = beat_sum + lane_m[i];
    end

    // tid values >= N_ID only pass through; they never touch accumulators
    assign id_ok    = ({1'b0, s_tid} < N_ID_W);
    assign acc_cur  = id_ok ? acc[s_tid] : CSUM_INIT;
    assign acc_next = acc_cur + beat_sum;

    // output slice can take a new beat when empty or being drained
    assign out_ld   = !m_tvalid || m_tready;
    assign s_tready = aresetn && (state == PASS) && out_ld;
    assign accept   = s_tvalid && s_tready;
    assign trl_load = (state == TRAIL) && out_ld;

    // FSM, accumulators and the output register slice
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= PASS;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
            trl_id   <= '0;
            trl_csum <= CSUM_INIT;
            for (int i = 0; i < N_ID; i++) acc[i] <= CSUM_INIT;
        end else begin
            case (state)
                PASS: begin
                    if (accept) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= s_tdata;
                        m_tkeep  <= s_tkeep;
                        m_tlast  <= 1'b0;
                        m_tid    <= s_tid;
                        if (id_ok) begin
                            acc[s_tid] <= acc_next;
                            if (s_tlast) begin
                                trl_id   <= s_tid;
                                trl_csum <= acc_next;
                                state    <= TRAIL;
                            end
                        end
                    end else if (m_tready) begin
                        m_tvalid <= 1'b0;
                    end
                end
                TRAIL: begin
                    if (trl_load) begin
                        m_tvalid    <= 1'b1;
                        m_tdata     <= {{(DATA_BITS-32){1'b0}}, trl_csum};
                        m_tkeep     <= {{(KEEP_BITS-4){1'b0}}, 4'hF};
                        m_tlast     <= 1'b1;
                        m_tid       <= trl_id;
                        acc[trl_id] <= CSUM_INIT;
                        state       <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

`ifdef CSUM_STAT_EN
    logic [N_ID-1:0][31:0] pkt_cnt;
    logic [N_ID-1:0][47:0] byte_cnt;
    logic                  sel_ok;

    assign sel_ok = ({1'b0, stat_sel} < N_ID_W);

    // per-ID packet/byte counters; a clear overrides any same-cycle update
    always_ff @(posedge aclk) begin
        if (!aresetn || stat_clr) begin
            for (int i = 0; i < N_ID; i++) begin
                pkt_cnt[i]  <= '0;
                byte_cnt[i] <= '0;
            end
        end else begin
            if (accept && id_ok)
                byte_cnt[s_tid] <= byte_cnt[s_tid] + 48'($countones(s_tkeep));
            if (trl_load)
                pkt_cnt[trl_id] <= pkt_cnt[trl_id] + 32'd1;
        end
    end

    // registered read of the selected ID's counters
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else begin
            stat_pkts  <= sel_ok ? pkt_cnt[stat_sel]  : 32'd0;
            stat_bytes <= sel_ok ? byte_cnt[stat_sel] : 48'd0;
        end
    end
`endif

endmodule

// File: tb/tb_user_axis_pkt_csum.sv
// Randomised + directed bench for user_axis_pkt_csum with a scoreboard.
// The driver feeds a byte-level checksum model that queues expected output
// beats; an independent monitor pops and compares on every output handshake.
module tb_user_axis_pkt_csum;
    localparam int          DB   = 512;
    localparam int          KB   = DB / 8;
    localparam int          NL   = DB / 32;
    localparam int          NID  = 4;
    localparam logic [31:0] INIT = 32'h0000_0000;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DB-1:0] s_tdata = '0;
    logic [KB-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic [1:0]    s_tid = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DB-1:0] m_tdata;
    logic [KB-1:0] m_tkeep;
    logic          m_tlast;
    logic [1:0]    m_tid;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
`ifdef CSUM_STAT_EN
    logic [1:0]    stat_sel = '0;
    logic [31:0]   stat_pkts;
    logic [47:0]   stat_bytes;
    logic          stat_clr = 1'b0;
`endif

    user_axis_pkt_csum #(.DATA_BITS(DB), .N_ID(NID), .CSUM_INIT(INIT)) dut (
        .aclk(aclk), .aresetn(aresetn),
`ifdef CSUM_STAT_EN
        .stat_sel(stat_sel), .stat_pkts(stat_pkts), .stat_bytes(stat_bytes), .stat_clr(stat_clr),
`endif
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DB-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
        logic [1:0]    id;
    } beat_t;

    beat_t       expq[$];
    logic [31:0] macc[NID];
    logic [31:0] last_trl[NID];
    int          vectors = 0;
    int          miscompares = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: stalled

    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // checksum from the byte view: byte b lands in bit position 8*(b%4) of a word
    function automatic logic [31:0] ref_sum(input logic [DB-1:0] d, input logic [KB-1:0] k);
        logic [31:0] s = 32'h0;
        for (int b = 0; b < KB; b++)
            if (k[b]) s = s + (32'(d[8*b +: 8]) << (8 * (b % 4)));
        return s;
    endfunction

    function automatic logic [DB-1:0] fill(input logic [31:0] v);
        logic [DB-1:0] d;
        for (int i = 0; i < NL; i++) d[32*i +: 32] = v;
        return d;
    endfunction

    function automatic logic [DB-1:0] rnd_data();
        logic [DB-1:0] d;
        for (int i = 0; i < NL; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_accept(input logic [DB-1:0] d, input logic [KB-1:0] k,
                                input logic last, input logic [1:0] id);
        beat_t e;
        e.data = d; e.keep = k; e.last = 1'b0; e.id = id;
        expq.push_back(e);
        if (int'(id) < NID) begin
            macc[id] = macc[id] + ref_sum(d, k);
            if (last) begin
                e.data = DB'(macc[id]);
                e.keep = KB'(4'hF);
                e.last = 1'b1;
                e.id   = id;
                expq.push_back(e);
                macc[id] = INIT;
            end
        end
    endtask

    // ready pattern, changed just after each rising edge
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    // monitor: checks stalled outputs hold and compares every handshake
    logic  held = 1'b0;
    beat_t hb;
    beat_t me;
    always @(negedge aclk) begin
        if (!aresetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_data", m_tdata, hb.data);
                chk("stall_ctl", DB'({m_tlast, m_tid, m_tkeep}), DB'({hb.last, hb.id, hb.keep}));
            end
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got tid=%0d tlast=%0d data=%0h expected none",
                             m_tid, m_tlast, m_tdata[31:0]);
                end else begin
                    me = expq.pop_front();
                    chk("out_data", m_tdata, me.data);
                    chk("out_ctl", DB'({m_tlast, m_tid, m_tkeep}), DB'({me.last, me.id, me.keep}));
                    if (m_tlast) last_trl[m_tid] = m_tdata[31:0];
                end
            end
            held = m_tvalid && !m_tready;
            hb.data = m_tdata; hb.keep = m_tkeep; hb.last = m_tlast; hb.id = m_tid;
        end
    end

    // drive one beat and wait (bounded) for it to be accepted
    task automatic send(input logic [DB-1:0] d, input logic [KB-1:0] k,
                        input logic last, input logic [1:0] id, output int waits);
        bit done = 0;
        s_tdata = d; s_tkeep = k; s_tlast = last; s_tid = id; s_tvalid = 1'b1;
        waits = 0;
        while (!done) begin
            @(negedge aclk);
            if (s_tready) begin
                model_accept(d, k, last, id);
                done = 1;
            end else begin
                waits++;
                if (waits > 200) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL accept_timeout: got no s_tready expected accept within 200 cycles");
                    done = 1;
                end
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("drain_left", DB'(expq.size()), DB'(0));
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        expq.delete();
        for (int i = 0; i < NID; i++) macc[i] = INIT;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_tvalid", DB'(m_tvalid), DB'(0));
        chk("rst_s_tready", DB'(s_tready), DB'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_m_tvalid", DB'(m_tvalid), DB'(0));
        idle(1);
    endtask

    initial begin
        int w;
        int tot;
        logic [DB-1:0] pd[8];
        logic [31:0]   p8;
        logic [KB-1:0] ones;
        ones = '1;
        for (int i = 0; i < NID; i++) begin macc[i] = INIT; last_trl[i] = 32'h0; end

        // reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_tdata", m_tdata, '0);
        chk("rst_m_ctl", DB'({m_tvalid, m_tlast, m_tid, m_tkeep}), DB'(0));
        chk("rst_s_tready0", DB'(s_tready), DB'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(2);

        // single beat, lanes of 1 on ID 0
        send(fill(32'h1), ones, 1'b1, 2'd0, w);
        drain();
        chk("t1_trailer", DB'(last_trl[0]), DB'(32'h0000_0010));

        // two beats on ID 1, second masked to lane0 only
        send(fill(32'hFFFF_FFFF), ones, 1'b0, 2'd1, w);
        pd[0] = rnd_data();
        pd[0][31:0] = 32'h2;
        send(pd[0], KB'(16'h000F), 1'b1, 2'd1, w);
        drain();
        chk("t2_trailer", DB'(last_trl[1]), DB'(32'hFFFF_FFF2));

        // interleaved IDs 0 and 2
        last_trl[0] = 32'h0;
        last_trl[2] = 32'h0;
        for (int i = 0; i < 6; i++)
            send(fill(32'h1), ones, i >= 4, (i % 2 == 0) ? 2'd0 : 2'd2, w);
        drain();
        chk("t3_trl_id0", DB'(last_trl[0]), DB'(32'h0000_0030));
        chk("t3_trl_id2", DB'(last_trl[2]), DB'(32'h0000_0030));

        // continuous 8-beat packet: exactly one stall cycle for the trailer
        p8 = 32'h0;
        for (int i = 0; i < 8; i++) begin pd[i] = rnd_data(); p8 = p8 + ref_sum(pd[i], ones); end
        tot = 0;
        for (int i = 0; i < 8; i++) begin send(pd[i], ones, i == 7, 2'd3, w); tot += w; end
        send(fill(32'h3), ones, 1'b1, 2'd2, w);
        tot += w;
        chk("t4_stall_cycles", DB'(tot), DB'(1));
        drain();
        chk("t4_trailer", DB'(last_trl[3]), DB'(p8));

        // same packet under 50% backpressure
        rdy_mode = 1;
        last_trl[3] = 32'h0;
        for (int i = 0; i < 8; i++) send(pd[i], ones, i == 7, 2'd3, w);
        drain();
        chk("t5_trailer_bp", DB'(last_trl[3]), DB'(p8));

        // reset while the trailer is pending
        rdy_mode = 2;
        idle(2);
        send(fill(32'h7), ones, 1'b1, 2'd0, w);
        idle(2);
        do_reset();
        rdy_mode = 0;
        idle(1);
        send(fill(32'h5), ones, 1'b1, 2'd0, w);
        drain();
        chk("t6_trailer_after_rst", DB'(last_trl[0]), DB'(32'h0000_0050));

        // random interleaved traffic under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [KB-1:0] k;
            k = ($urandom_range(0, 1) == 1) ? ones : {$urandom, $urandom};
            send(rnd_data(), k, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), w);
        end
        drain();

`ifdef CSUM_STAT_EN
        rdy_mode = 0;
        idle(1);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd_data(), ones, 1'b1, 2'd3, w);
        drain();
        stat_sel = 2'd3;
        idle(3);
        chk("stat_pkts", DB'(stat_pkts), DB'(3));
        chk("stat_bytes", DB'(stat_bytes), DB'(192));
        stat_clr = 1'b1;
        @(posedge aclk);
        #1;
        stat_clr = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("stat_pkts_clr", DB'(stat_pkts), DB'(0));
        chk("stat_bytes_clr", DB'(stat_bytes), DB'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
